dcache_store_buffer: RTL and testbench
======================================

DCACHE_STORE_BUFFER -- requirements
Module: dcache_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered line-write entries (power of two, 2..8).
REQ-002 SHALL have parameter SET_W, default 4, meaning the set-index width, matching the data-array address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports st_valid_i/st_ready_o  in/out  1/1  committed-store handshake.
REQ-006 SHALL have ports st_set_i  in  SET_W, st_off_i  in  3 (word within 256-bit line), st_mask_i  in  4 (byte enables), st_data_i  in  32.
REQ-007 SHALL have port sram_grant_i  input  1  data-array port free for a write this cycle.
REQ-008 SHALL have ports sram_csb_o, sram_web_o  out  1  active-low select/write; sram_addr_o  out  SET_W; sram_wmask_o  out  32; sram_din_o  out  256.
REQ-009 SHALL have ports lk_set_i  in  SET_W, lk_hit_o  out  1  load-conflict query.
REQ-010 SHALL have port empty_o  out  1  no pending entries (fence/writeback drain indication).

Function
REQ-011 SHALL accept a store on a cycle where st_valid_i && st_ready_o.
REQ-012 SHALL drive st_ready_o = !full, independent of same-cycle drain (no pass-through when full).
REQ-013 SHALL, on accept, expand the store to line form: mask bits [4*off+3:4*off] = st_mask_i, data replicated into all 8 words, all other mask bits 0.
REQ-014 SHALL store each entry as {set, mask[31:0], data[255:0]} in a circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1.
REQ-015 SHALL present the head entry combinationally when !empty && sram_grant_i: csb=0, web=0, addr=head.set, wmask=head.mask, din=head.data.
REQ-016 SHALL otherwise drive csb=1, web=1, wmask=0, addr=0, din=0.
REQ-017 SHALL pop the head on every cycle in which REQ-015 drives the write.
REQ-018 SHALL allow a store accepted in cycle N to be written to the array no earlier than cycle N+1.
REQ-019 SHALL support simultaneous push and pop; count is unchanged, and pointers wrap modulo DEPTH.
REQ-020 SHALL drive lk_hit_o = 1 combinationally iff any valid entry has set == lk_set_i, including the entry being popped in the current cycle.
REQ-021 SHALL drive empty_o = (count == 0).
REQ-022 SHALL never drop, reorder, or duplicate stores; write order to the array equals acceptance order.

Reset
REQ-023 SHALL, on rst, clear count and pointers asynchronously; st_ready_o=1, empty_o=1, lk_hit_o=0, and SRAM outputs at REQ-016 values.
REQ-024 SHALL discard all pending entries on reset mid-operation; entry payload registers need no reset.

Configuration
REQ-025 SHALL, with STORE_COALESCE_EN defined, merge an accepted store into the youngest entry when that entry's set matches and it is not being popped the same cycle: mask |= new mask, and new bytes overwrite old bytes; count is unchanged.
REQ-026 SHALL, with coalescing enabled, assert st_ready_o when full if the store merges into the youngest entry and that entry is not being popped.
REQ-027 SHALL, without STORE_COALESCE_EN, allocate a new entry for every accepted store.

Structure
REQ-028 SHALL take SET_W default, LINE_BYTES=32, and typedef sb_entry_t from shared package dcache_pkg.
REQ-029 SHALL place the word-to-line expansion of REQ-013 in sub-module dcache_sb_expand (purely combinational).

Verification
REQ-030 Reset check: assert rst mid-run with 3 entries -> empty_o=1, csb=1, and st_ready_o=1 on the next cycle.
REQ-031 Single store: set=5, off=2, mask=4'b0110, data=32'hAABBCCDD, grant=1 the next cycle -> addr=5, wmask=32'h00000600, din bytes [9:10]=CC,BB.
REQ-032 Full and wrap: push 4 stores with grant=0 -> st_ready_o=0; grant=1 for 6 cycles while pushing 2 more -> 6 writes in order, pointers wrap, empty_o=1 at the end.
REQ-033 Simultaneous push/pop at count=2 -> count stays 2; lk_set_i=popped set in the pop cycle -> lk_hit_o=1.
REQ-034 Coalesce (macro on): two stores to set 3, offsets 0 and 7, grant=0 -> one entry, wmask=32'hF000000F; macro off -> two entries.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache types: line geometry, store-buffer entry record and byte-merge helper.
package dcache_pkg;

    localparam int SET_W_DEFAULT = 4;
    localparam int LINE_BYTES    = 32;
    localparam int LINE_BITS     = LINE_BYTES * 8;

    typedef struct packed {
        logic [SET_W_DEFAULT-1:0] set;
        logic [LINE_BYTES-1:0]    mask;
        logic [LINE_BITS-1:0]     data;
    } sb_entry_t;

    // Newer bytes win wherever the incoming byte-enable is set.
    function automatic logic [LINE_BITS-1:0] merge_bytes(
        input logic [LINE_BITS-1:0]  old_data,
        input logic [LINE_BITS-1:0]  new_data,
        input logic [LINE_BYTES-1:0] new_mask
    );
        logic [LINE_BITS-1:0] res;
        for (int b = 0; b < LINE_BYTES; b++) begin
            res[8*b +: 8] = new_mask[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_store_buffer_if.sv
// Store-buffer bundle: committed-store handshake, data-array write port, load-conflict query, drain status.
interface dcache_store_buffer_if
    import dcache_pkg::*;
#(
    parameter int SET_W = SET_W_DEFAULT
);
    logic                  st_valid_i;
    logic                  st_ready_o;
    logic [SET_W-1:0]      st_set_i;
    logic [2:0]            st_off_i;
    logic [3:0]            st_mask_i;
    logic [31:0]           st_data_i;
    logic                  sram_grant_i;
    logic                  sram_csb_o;
    logic                  sram_web_o;
    logic [SET_W-1:0]      sram_addr_o;
    logic [LINE_BYTES-1:0] sram_wmask_o;
    logic [LINE_BITS-1:0]  sram_din_o;
    logic [SET_W-1:0]      lk_set_i;
    logic                  lk_hit_o;
    logic                  empty_o;

    modport master (
        output st_valid_i, st_set_i, st_off_i, st_mask_i, st_data_i, sram_grant_i, lk_set_i,
        input  st_ready_o, sram_csb_o, sram_web_o, sram_addr_o, sram_wmask_o, sram_din_o,
        input  lk_hit_o, empty_o
    );

    modport slave (
        input  st_valid_i, st_set_i, st_off_i, st_mask_i, st_data_i, sram_grant_i, lk_set_i,
        output st_ready_o, sram_csb_o, sram_web_o, sram_addr_o, sram_wmask_o, sram_din_o,
        output lk_hit_o, empty_o
    );

endinterface

// File: rtl/dcache_sb_expand.sv
// Expands a 32-bit word store into a full-line byte mask and word-replicated line data.
module dcache_sb_expand
    import dcache_pkg::*;
(
    input  logic [2:0]            off,
    input  logic [3:0]            mask,
    input  logic [31:0]           data,
    output logic [LINE_BYTES-1:0] line_mask,
    output logic [LINE_BITS-1:0]  line_data
);

    // Word offset selects the 4-bit lane; data is simply copied into every word.
    always_comb begin
        line_mask = LINE_BYTES'(mask) << {off, 2'b00};
        line_data = {8{data}};
    end

endmodule

// File: rtl/dcache_store_buffer.sv
// Data-cache store buffer: FIFO of line writes drained into the data array when granted.
// Optional build macro STORE_COALESCE_EN merges stores into the youngest entry of the same set.
module dcache_store_buffer
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SET_W = SET_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_store_buffer_if.slave  sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic [PTR_W-1:0]      young_s;
    logic [PTR_W-1:0]      rel_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  merge_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  hit_s;
    logic [LINE_BYTES-1:0] new_mask_s;
    logic [LINE_BITS-1:0]  new_data_s;
    sb_entry_t             head_s;

    dcache_sb_expand u_expand (
        .off       (sb.st_off_i),
        .mask      (sb.st_mask_i),
        .data      (sb.st_data_i),
        .line_mask (new_mask_s),
        .line_data (new_data_s)
    );

    // Occupancy, drain and accept decisions.
    always_comb begin
        empty_s = (count_r == CNT_W'(0));
        full_s  = (count_r == CNT_W'(DEPTH));
        young_s = tail_r - PTR_W'(1);
        head_s  = mem_r[head_r];
        pop_s   = !empty_s && sb.sram_grant_i;
`ifdef STORE_COALESCE_EN
        // The youngest is only popped when it is also the head.
        merge_s = !empty_s && (mem_r[young_s].set == SET_W_DEFAULT'(sb.st_set_i))
                  && !(pop_s && (count_r == CNT_W'(1)));
`else
        merge_s = 1'b0;
`endif
        ready_s  = !full_s || merge_s;
        accept_s = sb.st_valid_i && ready_s;
        push_s   = accept_s && !merge_s;
    end

    // Data-array write port, status and load-conflict query.
    always_comb begin
        sb.st_ready_o = ready_s;
        sb.empty_o    = empty_s;
        if (pop_s) begin
            sb.sram_csb_o   = 1'b0;
            sb.sram_web_o   = 1'b0;
            sb.sram_addr_o  = SET_W'(head_s.set);
            sb.sram_wmask_o = head_s.mask;
            sb.sram_din_o   = head_s.data;
        end else begin
            sb.sram_csb_o   = 1'b1;
            sb.sram_web_o   = 1'b1;
            sb.sram_addr_o  = SET_W'(0);
            sb.sram_wmask_o = {LINE_BYTES{1'b0}};
            sb.sram_din_o   = {LINE_BITS{1'b0}};
        end
        hit_s = 1'b0;
        rel_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rel_s = PTR_W'(i) - head_r;
            if (({1'b0, rel_s} < count_r) && (SET_W'(mem_r[i].set) == sb.lk_set_i)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        sb.lk_hit_o = hit_s;
    end

    // Pointers and count; pointer wrap falls out of the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload; stale contents are harmless because count gates validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= '{set:  SET_W_DEFAULT'(sb.st_set_i),
                               mask: new_mask_s,
                               data: new_data_s};
        end else if (merge_s && accept_s) begin
            mem_r[young_s].mask <= mem_r[young_s].mask | new_mask_s;
            mem_r[young_s].data <= merge_bytes(mem_r[young_s].data, new_data_s, new_mask_s);
        end
    end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed bench for dcache_store_buffer: queue-based reference model compared every cycle plus literal checks.
module tb_dcache_store_buffer;
    import dcache_pkg::*;

    localparam int DEPTH = 4;
    localparam int SW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_store_buffer_if #(.SET_W(SW)) sb_if ();

    dcache_store_buffer #(.DEPTH(DEPTH), .SET_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    typedef struct {
        logic [SW-1:0]  set;
        logic [31:0]    mask;
        logic [255:0]   data;
    } mentry_t;

    mentry_t     q[$];
    logic [SW-1:0] wr_sets[$];
    int total = 0;
    int bad   = 0;

    function automatic bit m_pop();
        return (q.size() > 0) && (sb_if.sram_grant_i == 1'b1);
    endfunction

    function automatic bit m_merge();
`ifdef STORE_COALESCE_EN
        if (q.size() == 0) return 1'b0;
        if (q[q.size()-1].set != sb_if.st_set_i) return 1'b0;
        if (m_pop() && q.size() == 1) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        return (q.size() < DEPTH) || m_merge();
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        bit p;
        bit h;
        p = m_pop();
        h = 1'b0;
        foreach (q[i]) if (q[i].set == sb_if.lk_set_i) h = 1'b1;
        check("m_ready",  256'(sb_if.st_ready_o), 256'(m_ready()));
        check("m_empty",  256'(sb_if.empty_o),    256'(q.size() == 0));
        check("m_lk_hit", 256'(sb_if.lk_hit_o),   256'(h));
        check("m_csb",    256'(sb_if.sram_csb_o), 256'(!p));
        check("m_web",    256'(sb_if.sram_web_o), 256'(!p));
        if (p) begin
            check("m_addr",  256'(sb_if.sram_addr_o),  256'(q[0].set));
            check("m_wmask", 256'(sb_if.sram_wmask_o), 256'(q[0].mask));
            check("m_din",   sb_if.sram_din_o,         q[0].data);
        end else begin
            check("m_addr0",  256'(sb_if.sram_addr_o),  256'(0));
            check("m_wmask0", 256'(sb_if.sram_wmask_o), 256'(0));
            check("m_din0",   sb_if.sram_din_o,         256'(0));
        end
        if (sb_if.sram_csb_o == 1'b0) wr_sets.push_back(sb_if.sram_addr_o);
    end

    // Model state update on the same edge the DUT commits.
    always @(posedge clk or posedge rst) begin : mdl
        bit      p;
        bit      mg;
        bit      acc;
        int      y;
        mentry_t e;
        if (rst) begin
            q.delete();
        end else begin
            p   = m_pop();
            mg  = m_merge();
            acc = sb_if.st_valid_i && m_ready();
            e.set  = sb_if.st_set_i;
            e.mask = 32'(sb_if.st_mask_i) << (4 * sb_if.st_off_i);
            e.data = {8{sb_if.st_data_i}};
            if (p) void'(q.pop_front());
            if (acc) begin
                if (mg) begin
                    y = q.size() - 1;
                    for (int b = 0; b < 32; b++)
                        if (e.mask[b]) q[y].data[8*b +: 8] = e.data[8*b +: 8];
                    q[y].mask = q[y].mask | e.mask;
                end else begin
                    q.push_back(e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [2:0] o,
                         input logic [3:0] m, input logic [31:0] d, input logic g,
                         input logic [SW-1:0] lk);
        sb_if.st_valid_i   = v;
        sb_if.st_set_i     = s;
        sb_if.st_off_i     = o;
        sb_if.st_mask_i    = m;
        sb_if.st_data_i    = d;
        sb_if.sram_grant_i = g;
        sb_if.lk_set_i     = lk;
    endtask

    initial begin
        logic [SW-1:0] exp_sets[$];
        rst = 1'b1;
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b0, 4'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_empty", 256'(sb_if.empty_o),    256'(1'b1));
        check("rst_ready", 256'(sb_if.st_ready_o), 256'(1'b1));
        check("rst_csb",   256'(sb_if.sram_csb_o), 256'(1'b1));

        // Single store: not writable in its accept cycle, written the next.
        drive(1'b1, 4'd5, 3'd2, 4'b0110, 32'hAABBCCDD, 1'b1, 4'd5);
        #1;
        check("single_no_bypass", 256'(sb_if.sram_csb_o), 256'(1'b1));
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b1, 4'd5);
        #1;
        check("single_csb",   256'(sb_if.sram_csb_o),   256'(1'b0));
        check("single_addr",  256'(sb_if.sram_addr_o),  256'(5));
        check("single_wmask", 256'(sb_if.sram_wmask_o), 256'(32'h00000600));
        check("single_b9",    256'(sb_if.sram_din_o[79:72]), 256'(8'hCC));
        check("single_b10",   256'(sb_if.sram_din_o[87:80]), 256'(8'hBB));
        check("single_hit",   256'(sb_if.lk_hit_o),     256'(1'b1));
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b0, 4'd5);
        #1;
        check("single_empty", 256'(sb_if.empty_o), 256'(1'b1));

        // Fill, then drain six with wrap while two more arrive.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, SW'(i), 3'(i), 4'hF, 32'h11111111 * i, 1'b0, 4'd0);
            cyc();
        end
        wr_sets.delete();
        drive(1'b1, 4'd9, 3'd0, 4'hF, 32'h99999999, 1'b1, 4'd0);
        #1;
        check("full_ready", 256'(sb_if.st_ready_o), 256'(1'b0));
        cyc();
        drive(1'b1, 4'd5, 3'd5, 4'h3, 32'h55555555, 1'b1, 4'd0);
        cyc();
        drive(1'b1, 4'd6, 3'd6, 4'hC, 32'h66666666, 1'b1, 4'd0);
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b1, 4'd0);
        cyc();
        cyc();
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b0, 4'd0);
        #1;
        check("wrap_empty", 256'(sb_if.empty_o), 256'(1'b1));
        check("wrap_count", 256'(wr_sets.size()), 256'(6));
        exp_sets = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        for (int i = 0; i < 6; i++)
            if (i < wr_sets.size()) check("wrap_order", 256'(wr_sets[i]), 256'(exp_sets[i]));

        // Push and pop together at count 2; the popped set still hits.
        drive(1'b1, 4'd7, 3'd0, 4'h1, 32'h77777777, 1'b0, 4'd0);
        cyc();
        drive(1'b1, 4'd8, 3'd1, 4'h2, 32'h88888888, 1'b0, 4'd0);
        cyc();
        wr_sets.delete();
        drive(1'b1, 4'd10, 3'd2, 4'h4, 32'hA0A0A0A0, 1'b1, 4'd7);
        #1;
        check("pp_hit",   256'(sb_if.lk_hit_o),   256'(1'b1));
        check("pp_ready", 256'(sb_if.st_ready_o), 256'(1'b1));
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b1, 4'd2);
        #1;
        check("pp_miss", 256'(sb_if.lk_hit_o), 256'(1'b0));
        cyc();
        check("pp_one_left", 256'(sb_if.empty_o), 256'(1'b0));
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b0, 4'd0);
        #1;
        check("pp_empty", 256'(sb_if.empty_o), 256'(1'b1));
        check("pp_count", 256'(wr_sets.size()), 256'(3));
        exp_sets = '{4'd7, 4'd8, 4'd10};
        for (int i = 0; i < 3; i++)
            if (i < wr_sets.size()) check("pp_order", 256'(wr_sets[i]), 256'(exp_sets[i]));

        // Two stores to set 3 at opposite ends of the line.
        drive(1'b1, 4'd3, 3'd0, 4'hF, 32'h11223344, 1'b0, 4'd0);
        cyc();
        drive(1'b1, 4'd3, 3'd7, 4'hF, 32'h55667788, 1'b0, 4'd0);
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b1, 4'd0);
        #1;
`ifdef STORE_COALESCE_EN
        check("co_wmask", 256'(sb_if.sram_wmask_o), 256'(32'hF000000F));
        check("co_w0",    256'(sb_if.sram_din_o[31:0]),    256'(32'h11223344));
        check("co_w7",    256'(sb_if.sram_din_o[255:224]), 256'(32'h55667788));
        cyc();
        check("co_empty", 256'(sb_if.empty_o), 256'(1'b1));
`else
        check("nc_wmask0", 256'(sb_if.sram_wmask_o), 256'(32'h0000000F));
        cyc();
        check("nc_wmask1", 256'(sb_if.sram_wmask_o), 256'(32'hF0000000));
        check("nc_w7",     256'(sb_if.sram_din_o[255:224]), 256'(32'h55667788));
        cyc();
        check("nc_empty", 256'(sb_if.empty_o), 256'(1'b1));
`endif

        // Coalesce byte overwrite (model-checked when merging is built in).
        drive(1'b1, 4'd2, 3'd0, 4'b0011, 32'hAAAAAAAA, 1'b0, 4'd2);
        cyc();
        drive(1'b1, 4'd2, 3'd0, 4'b0001, 32'hBBBBBBBB, 1'b0, 4'd2);
        cyc();
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b1, 4'd2);
        cyc();
        cyc();

        // Reset with three pending entries discards them.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, SW'(i), 3'd0, 4'hF, 32'hC0DE0000 + i, 1'b0, 4'd1);
            cyc();
        end
        drive(1'b0, 4'd0, 3'd0, 4'h0, 32'h0, 1'b1, 4'd1);
        rst = 1'b1;
        #1;
        check("mrst_empty", 256'(sb_if.empty_o),    256'(1'b1));
        check("mrst_csb",   256'(sb_if.sram_csb_o), 256'(1'b1));
        check("mrst_ready", 256'(sb_if.st_ready_o), 256'(1'b1));
        check("mrst_hit",   256'(sb_if.lk_hit_o),   256'(1'b0));
        cyc();
        rst = 1'b0;
        #1;
        check("post_empty", 256'(sb_if.empty_o),    256'(1'b1));
        check("post_csb",   256'(sb_if.sram_csb_o), 256'(1'b1));
        check("post_ready", 256'(sb_if.st_ready_o), 256'(1'b1));
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
